// File: rtl/rc_servo_pkg.sv
// -----------------------------------------------------------------------------
// rc_servo_pkg
// Shared definitions for the RC servo time-division scheduler:
//   - rc_sched_state_t : states of the single shared channel FSM
//   - DEF_*            : default timing constants for a 50 MHz clock
//   - rc_on_clamp      : clamps a raw ON time into [lo, hi]
// -----------------------------------------------------------------------------
package rc_servo_pkg;

    typedef enum bit [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ON   = 2'd2,
        S_OFF  = 2'd3
    } rc_sched_state_t;

    // 2.5 ms slot, 1.0 ms .. 2.0 ms pulse at 50 MHz
    localparam int DEF_SLOT_COUNT = 125000;
    localparam int DEF_MIN_ON     = 50000;
    localparam int DEF_MAX_ON     = 100000;

    function automatic int rc_on_clamp(input int value, input int lo, input int hi);
        int result;
        result = value;
        if (value < lo) begin
            result = lo;
        end else if (value > hi) begin
            result = hi;
        end
        return result;
    endfunction

endpackage

// File: rtl/rc_servo_on_timer.sv
// -----------------------------------------------------------------------------
// rc_servo_on_timer
// Loadable down-counter used to time one pulse.
//   clk, reset  : clock, synchronous active-high reset (count -> 0)
//   clear       : synchronous clear (count -> 0), e.g. when the owner goes idle
//   load        : load load_value into the counter
//   enable      : decrement by one per cycle (holds at zero)
//   load_value  : TIMER_WIDTH-bit pulse length in clocks
//   done        : high while the count equals 1, i.e. in the last ON cycle
// -----------------------------------------------------------------------------
module rc_servo_on_timer #(
    parameter int TIMER_WIDTH = 17
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   load,
    input  logic                   enable,
    input  logic [TIMER_WIDTH-1:0] load_value,
    output logic                   done
);

    logic [TIMER_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - TIMER_WIDTH'(1);
        end
    end

    assign done = (count == TIMER_WIDTH'(1));

endmodule

// File: rtl/rc_servo_scheduler.sv
// -----------------------------------------------------------------------------
// rc_servo_scheduler
// Time-division scheduler for NUM_CHANNELS RC servo outputs sharing one ON-time
// counter. The frame is NUM_CHANNELS slots of SLOT_COUNT clocks; channel k may
// only pulse in slot k. ON times and the enable mask are double-buffered and
// move from shadow to active at frame end (and when run rises).
//   clk, reset     : clock, synchronous active-high reset
//   run            : global enable, low parks everything at slot 0 / idle
//   cfg_wr         : one-cycle write strobe
//   cfg_sel        : 0 = ON time for cfg_addr, 1 = enable mask
//   cfg_addr       : channel index for ON-time writes
//   cfg_data       : raw ON time in clocks, or enable mask in the LSBs
//   servo_out      : servo pulse outputs, at most one bit high
//   frame_start    : one-cycle marker when the counters wrap into slot 0
//   active_channel : current slot index
//   pulse_active   : high while a pulse is being driven
// -----------------------------------------------------------------------------
module rc_servo_scheduler
    import rc_servo_pkg::*;
#(
    parameter  int NUM_CHANNELS = 8,
    parameter  int SLOT_COUNT   = DEF_SLOT_COUNT,
    parameter  int TIMER_WIDTH  = 17,
    parameter  int MIN_ON       = DEF_MIN_ON,
    parameter  int MAX_ON       = DEF_MAX_ON,
    localparam int ADDR_W       = $clog2(NUM_CHANNELS),
    localparam int CFG_W        = (TIMER_WIDTH > NUM_CHANNELS) ? TIMER_WIDTH : NUM_CHANNELS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    cfg_wr,
    input  logic                    cfg_sel,
    input  logic [ADDR_W-1:0]       cfg_addr,
    input  logic [CFG_W-1:0]        cfg_data,
    output logic [NUM_CHANNELS-1:0] servo_out,
    output logic                    frame_start,
    output logic [ADDR_W-1:0]       active_channel,
    output logic                    pulse_active
);

    localparam int CNT_W = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;

    logic [CNT_W-1:0]        slot_cnt;
    logic [ADDR_W-1:0]       slot_idx;
    rc_sched_state_t         state;
    logic                    run_q;

    logic [TIMER_WIDTH-1:0]  shadow_on [NUM_CHANNELS];
    logic [TIMER_WIDTH-1:0]  active_on [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] shadow_en;
    logic [NUM_CHANNELS-1:0] active_en;

    logic                    slot_last;
    logic                    frame_last;
    logic                    run_rise;
    logic                    copy_cfg;
    logic [NUM_CHANNELS-1:0] start_en;
    logic [TIMER_WIDTH-1:0]  on_clamped;
    logic                    timer_done;

    always_comb begin
        slot_last  = (slot_cnt == CNT_W'(SLOT_COUNT - 1));
        frame_last = slot_last && (slot_idx == ADDR_W'(NUM_CHANNELS - 1));
        run_rise   = run && !run_q;
        copy_cfg   = run && (run_rise || frame_last);
        // The copy on run rise lands at the clock edge, but slot 0 is
        // evaluated in that same cycle, so look at the shadow mask directly.
        start_en   = run_rise ? shadow_en : active_en;
        on_clamped = TIMER_WIDTH'(rc_on_clamp(int'(active_on[slot_idx]), MIN_ON, MAX_ON));
    end

    // Slot / frame counters
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            slot_cnt <= '0;
            slot_idx <= '0;
        end else if (slot_last) begin
            slot_cnt <= '0;
            if (slot_idx == ADDR_W'(NUM_CHANNELS - 1)) begin
                slot_idx <= '0;
            end else begin
                slot_idx <= slot_idx + ADDR_W'(1);
            end
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

    // Registered so it is high exactly in the cycle the counters sit at 0/0
    // after a wrap. Counters parked at zero while run is low are not a frame
    // boundary, so the first frame after run rises carries no marker.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            run_q       <= run;
            frame_start <= run && frame_last;
        end
    end

    // Shared channel FSM
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if ((slot_cnt == '0) && start_en[slot_idx]) state <= S_LOAD;
                S_LOAD: state <= S_ON;
                S_ON:   if (timer_done) state <= S_OFF;
                S_OFF:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Double-buffered configuration. A write in the copy cycle lands only
    // in shadow and therefore reaches active one frame later.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shadow_on[i] <= TIMER_WIDTH'(MIN_ON);
                active_on[i] <= TIMER_WIDTH'(MIN_ON);
            end
            shadow_en <= '0;
            active_en <= '0;
        end else begin
            if (copy_cfg) begin
                active_on <= shadow_on;
                active_en <= shadow_en;
            end
            if (cfg_wr) begin
                if (cfg_sel) begin
                    shadow_en <= cfg_data[NUM_CHANNELS-1:0];
                end else if (int'(cfg_addr) < NUM_CHANNELS) begin
                    shadow_on[cfg_addr] <= cfg_data[TIMER_WIDTH-1:0];
                end
            end
        end
    end

    rc_servo_on_timer #(
        .TIMER_WIDTH (TIMER_WIDTH)
    ) u_on_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (!run),
        .load       (state == S_LOAD),
        .enable     (state == S_ON),
        .load_value (on_clamped),
        .done       (timer_done)
    );

    always_comb begin
        servo_out = '0;
        if (state == S_ON) begin
            servo_out = NUM_CHANNELS'(1) << slot_idx;
        end
    end

    assign pulse_active   = (state == S_ON);
    assign active_channel = slot_idx;

endmodule

// File: tb/tb_rc_servo_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rc_servo_scheduler
// Scoreboard bench: stimulus pushes the expected {channel, width} of every
// pulse; a negedge monitor measures each pulse and pops/compares on its end.
// ph is the bench's own count of running cycles, i.e. the frame position.
// -----------------------------------------------------------------------------
module tb_rc_servo_scheduler;

    localparam int NCH   = 4;
    localparam int SLOT  = 100;
    localparam int TW    = 8;
    localparam int MINON = 10;
    localparam int MAXON = 90;
    localparam int FRAME = NCH * SLOT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       cfg_wr = 1'b0;
    logic       cfg_sel = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic [3:0] servo_out;
    logic       frame_start;
    logic [1:0] active_channel;
    logic       pulse_active;

    int checks = 0;
    int errors = 0;
    int ph = 0;

    typedef struct {
        int ch;
        int width;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rc_servo_scheduler #(
        .NUM_CHANNELS (NCH),
        .SLOT_COUNT   (SLOT),
        .TIMER_WIDTH  (TW),
        .MIN_ON       (MINON),
        .MAX_ON       (MAXON)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .cfg_wr         (cfg_wr),
        .cfg_sel        (cfg_sel),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .servo_out      (servo_out),
        .frame_start    (frame_start),
        .active_channel (active_channel),
        .pulse_active   (pulse_active)
    );

    always @(posedge clk) ph <= (run && !reset) ? ph + 1 : 0;

    // ---------------- monitor ----------------
    logic in_pulse = 1'b0;
    logic p_bad = 1'b0;
    int   p_ch = 0;
    int   p_start = 0;
    int   p_w = 0;

    always @(negedge clk) begin
        int   cur;
        exp_t e;
        checks++;
        if ($countones(servo_out) > 1) begin
            errors++;
            $display("FAIL onehot: servo_out=%b required at most one bit high", servo_out);
        end
        checks++;
        if (int'(active_channel) != (ph / SLOT) % NCH) begin
            errors++;
            $display("FAIL active_channel at ph=%0d: got %0d expected %0d",
                     ph, active_channel, (ph / SLOT) % NCH);
        end
        checks++;
        if (frame_start !== ((ph != 0) && (ph % FRAME == 0))) begin
            errors++;
            $display("FAIL frame_start at ph=%0d: got %b expected %b",
                     ph, frame_start, ((ph != 0) && (ph % FRAME == 0)));
        end
        if (servo_out != '0) begin
            cur = 0;
            for (int i = NCH - 1; i >= 0; i--) if (servo_out[i]) cur = i;
            if (!in_pulse) begin
                in_pulse = 1'b1;
                p_ch     = cur;
                p_start  = ph;
                p_w      = 0;
                p_bad    = 1'b0;
            end
            p_w++;
            if (cur != p_ch || !pulse_active || int'(active_channel) != p_ch) p_bad = 1'b1;
        end else begin
            checks++;
            if (pulse_active !== 1'b0) begin
                errors++;
                $display("FAIL idle_pulse_active at ph=%0d: got %b expected 0", ph, pulse_active);
            end
            if (in_pulse) begin
                in_pulse = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: ch=%0d width=%0d expected no pulse", p_ch, p_w);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (p_ch != e.ch) begin
                        errors++;
                        $display("FAIL pulse_channel: got %0d expected %0d", p_ch, e.ch);
                    end
                    checks++;
                    if (p_w != e.width) begin
                        errors++;
                        $display("FAIL pulse_width ch%0d: got %0d expected %0d", p_ch, p_w, e.width);
                    end
                    checks++;
                    if (p_start % FRAME != e.ch * SLOT + 2) begin
                        errors++;
                        $display("FAIL pulse_start ch%0d: got offset %0d expected %0d",
                                 p_ch, p_start % FRAME, e.ch * SLOT + 2);
                    end
                    checks++;
                    if (p_bad) begin
                        errors++;
                        $display("FAIL pulse_consistency ch%0d: got inconsistent flags expected steady", p_ch);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ph(input int target);
        int n;
        n = 0;
        while (ph != target && n < 5000) begin
            tick(1);
            n++;
        end
        if (ph != target) begin
            $display("FAIL wait_ph: got ph=%0d expected %0d", ph, target);
            $fatal(1, "position never reached");
        end
    endtask

    task automatic wr_on(input int ch, input int val);
        cfg_wr   = 1'b1;
        cfg_sel  = 1'b0;
        cfg_addr = 2'(ch);
        cfg_data = 8'(val);
        tick(1);
        cfg_wr   = 1'b0;
    endtask

    task automatic wr_mask(input int m);
        cfg_wr   = 1'b1;
        cfg_sel  = 1'b1;
        cfg_data = 8'(m);
        tick(1);
        cfg_wr   = 1'b0;
    endtask

    initial begin
        tick(3);
        chk("rst_servo_out", int'(servo_out), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_pulse_active", int'(pulse_active), 0);
        chk("rst_active_channel", int'(active_channel), 0);
        reset = 1'b0;
        tick(1);

        // ch0 alone, 25 cycles, frames 0 and 1
        wr_on(0, 25);
        wr_mask(4'b0001);
        sb.push_back('{0, 25});
        sb.push_back('{0, 25});
        run = 1'b1;

        // clamp both ends; frames 2 and 3
        wait_ph(450);
        wr_on(1, 5);
        wr_on(2, 200);
        wr_mask(4'b0110);
        sb.push_back('{1, 10});
        sb.push_back('{2, 90});
        sb.push_back('{1, 10});
        sb.push_back('{2, 90});

        // back to ch0 with on[0]=25 for frame 4
        wait_ph(1250);
        wr_mask(4'b0001);
        sb.push_back('{0, 25});

        // mid-pulse write: frame 4 keeps 25, frame 5 uses 40
        wait_ph(1610);
        wr_on(0, 40);
        sb.push_back('{0, 40});

        // write in the last frame cycle: frame 6 still 40, frame 7 gets 60
        wait_ph(2399);
        sb.push_back('{0, 40});
        sb.push_back('{0, 60});
        wr_on(0, 60);

        // drop run in ON cycle 7 of frame 8
        wait_ph(3208);
        sb.push_back('{0, 7});
        run = 1'b0;
        tick(5);
        sb.push_back('{0, 60});
        run = 1'b1;

        // reset in the middle of the next frame's pulse
        wait_ph(420);
        sb.push_back('{0, 19});
        reset = 1'b1;
        tick(1);
        chk("midrst_servo_out", int'(servo_out), 0);
        chk("midrst_pulse_active", int'(pulse_active), 0);
        chk("midrst_active_channel", int'(active_channel), 0);
        chk("midrst_frame_start", int'(frame_start), 0);
        reset = 1'b0;

        // mask cleared by reset: silent until re-enabled; ON time back to MIN_ON
        wait_ph(500);
        wr_mask(4'b0001);
        sb.push_back('{0, 10});
        wait_ph(900);

        for (int i = 0; i < 1000 && sb.size() != 0; i++) tick(1);
        chk("scoreboard_drained", sb.size(), 0);
        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
